// File: rtl/vga_mem_pkg.sv
// Shared types and constants for the VGA frame fetch path.
//   WORDS_PER_FRAME : RAM words making up one 640x480 1-bpp frame.
//   fetch_state_t   : display fetch engine state.
//   grant_t         : owner of a RAM slot in a given cycle.
package vga_mem_pkg;

   localparam int WORDS_PER_FRAME = 19200;

   typedef enum logic {
      IDLE,
      FETCH
   } fetch_state_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_DISP,
      GNT_WR
   } grant_t;

endpackage

// File: rtl/pix_word_fifo.sv
// Show-ahead pixel word FIFO: the head word is presented on data_o whenever
// the FIFO is non-empty, and pop_i retires it at the next clock edge.
//   clk_50   in   clock
//   reset_n  in   asynchronous active-low reset
//   clear_i  in   synchronous flush; wins over push/pop in the same cycle
//   push_i   in   write data_i (ignored when full unless a pop frees a slot)
//   data_i   in   word to push
//   pop_i    in   retire the head word (ignored when empty)
//   data_o   out  head word, zero when empty
//   valid_o  out  FIFO non-empty
//   count_o  out  number of stored words
module pix_word_fifo #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                               clk_50,
   input  logic                               reset_n,
   input  logic                               clear_i,
   input  logic                               push_i,
   input  logic [DATA_W-1:0]                  data_i,
   input  logic                               pop_i,
   output logic [DATA_W-1:0]                  data_o,
   output logic                               valid_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   // Head must be visible in the same cycle it is written behind, so the
   // storage is read combinationally; at this depth it stays in fabric.
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;
   logic             full;

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap naturally because the depth is a power of two.
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_50) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign valid_o = (count_q != '0);
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/vga_frame_fetch_arbiter.sv
// Arbitrates the single-port frame RAM between the VGA display prefetch and
// the frame loader. Display words are fetched into a show-ahead FIFO; when
// the prefetch is short of LOW_WATER words the display owns every slot,
// otherwise slots alternate and an unused writer slot falls to display.
//   clk_50       in   clock
//   reset_n      in   asynchronous active-low reset
//   frame_start  in   pulse: restart fetch at word 0, flush FIFO and in-flight reads
//   pix_pop      in   consume FIFO head
//   pix_word     out  FIFO head word
//   pix_valid    out  FIFO non-empty
//   underflow    out  sticky: pop while empty (cleared by frame_start)
//   frame_done   out  pulse alongside the issue of the last frame word
//   wr_valid/wr_addr/wr_data  in   loader write request
//   wr_ready     out  combinational: write granted this cycle
//   mem_en/mem_we/mem_addr/mem_wdata  out  registered RAM command
//   mem_rdata    in   RAM data, one cycle after a read is sampled
module vga_frame_fetch_arbiter #(
   parameter int DATA_W          = 16,
   parameter int ADDR_W          = 15,
   parameter int WORDS_PER_FRAME = vga_mem_pkg::WORDS_PER_FRAME,
   parameter int FIFO_DEPTH      = 8,
   parameter int LOW_WATER       = 3
) (
   input  logic              clk_50,
   input  logic              reset_n,
   input  logic              frame_start,
   input  logic              pix_pop,
   output logic [DATA_W-1:0] pix_word,
   output logic              pix_valid,
   output logic              underflow,
   output logic              frame_done,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   import vga_mem_pkg::*;

   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int FILL_W = CNT_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_FRAME - 1);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic              last_wr_q, last_wr_d;
   logic              rd_pend_q, rd_pend_d;
   logic              underflow_q, underflow_d;
   logic              frame_done_q, frame_done_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   grant_t            grant;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_valid;
   logic [FILL_W-1:0] fill;
   logic              need;
   logic              issue_disp;

   pix_word_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_50  (clk_50),
      .reset_n (reset_n),
      .clear_i (frame_start),
      .push_i  (rd_pend_q),
      .data_i  (mem_rdata),
      .pop_i   (pix_pop),
      .data_o  (pix_word),
      .valid_o (fifo_valid),
      .count_o (fifo_count)
   );

   // Fill counts words already buffered plus reads still on their way, so
   // the FIFO can never be over-subscribed.
   assign fill = {1'b0, fifo_count} + {1'b0, inflight_q};
   assign need = (state_q == FETCH) && (fill < FILL_W'(FIFO_DEPTH));

   always_comb begin
      grant = GNT_NONE;
      if (frame_start || !need) begin
         if (wr_valid) grant = GNT_WR;
      end else if (fill < FILL_W'(LOW_WATER)) begin
         grant = GNT_DISP;
      end else if (last_wr_q || !wr_valid) begin
         grant = GNT_DISP;
      end else begin
         grant = GNT_WR;
      end
   end

   assign issue_disp = (grant == GNT_DISP);
   assign wr_ready   = (grant == GNT_WR) && reset_n;

   always_comb begin
      state_d      = state_q;
      rd_addr_d    = rd_addr_q;
      last_wr_d    = last_wr_q;
      underflow_d  = underflow_q;
      frame_done_d = 1'b0;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      // A read on the bus now is sampled by the RAM at this edge and its
      // data is pushed one cycle later.
      rd_pend_d    = mem_en_q && !mem_we_q;
      inflight_d   = inflight_q + {{(CNT_W-1){1'b0}}, issue_disp}
                                - {{(CNT_W-1){1'b0}}, rd_pend_q};

      if (pix_pop && !fifo_valid) underflow_d = 1'b1;

      case (grant)
         GNT_DISP: begin
            mem_en_d     = 1'b1;
            mem_addr_d   = rd_addr_q;
            rd_addr_d    = rd_addr_q + ADDR_W'(1);
            last_wr_d    = 1'b0;
            if (rd_addr_q == LAST_ADDR) begin
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end
         end
         GNT_WR: begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
            last_wr_d   = 1'b1;
         end
         default: ;
      endcase

      // Restart: the read sampled at this edge belongs to the old frame, so
      // its return is suppressed; the one returning now is flushed by clear.
      if (frame_start) begin
         state_d     = FETCH;
         rd_addr_d   = '0;
         inflight_d  = '0;
         rd_pend_d   = 1'b0;
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rd_addr_q    <= '0;
         inflight_q   <= '0;
         last_wr_q    <= 1'b1;
         rd_pend_q    <= 1'b0;
         underflow_q  <= 1'b0;
         frame_done_q <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         rd_addr_q    <= rd_addr_d;
         inflight_q   <= inflight_d;
         last_wr_q    <= last_wr_d;
         rd_pend_q    <= rd_pend_d;
         underflow_q  <= underflow_d;
         frame_done_q <= frame_done_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign pix_valid  = fifo_valid;
   assign underflow  = underflow_q;
   assign frame_done = frame_done_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_vga_frame_fetch_arbiter.sv
// Bench for vga_frame_fetch_arbiter: a RAM model answers the DUT, and a
// queue-based reference model predicts every output each cycle.
module tb_vga_frame_fetch_arbiter;

   localparam int DW    = 16;
   localparam int AW    = 15;
   localparam int WPF   = 19200;
   localparam int DEPTH = 8;
   localparam int LW    = 3;

   logic          clk_50 = 1'b0;
   logic          reset_n = 1'b1;
   logic          frame_start = 1'b0;
   logic          pix_pop = 1'b0;
   logic          wr_valid = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] pix_word;
   logic          pix_valid, underflow, frame_done, wr_ready;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;

   vga_frame_fetch_arbiter dut (
      .clk_50      (clk_50),
      .reset_n     (reset_n),
      .frame_start (frame_start),
      .pix_pop     (pix_pop),
      .pix_word    (pix_word),
      .pix_valid   (pix_valid),
      .underflow   (underflow),
      .frame_done  (frame_done),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #10 clk_50 = ~clk_50;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] init_word(input int a);
      if (a == 0) return 16'hA5A5;
      return 16'(a * 40503) ^ 16'h5A3C;
   endfunction

   // ---------------- RAM model driven by the DUT ----------------
   logic [15:0] ram [0:32767];
   initial begin
      for (int i = 0; i < 32768; i++) ram[i] = init_word(i);
      forever begin
         @(posedge clk_50);
         if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else        mem_rdata <= ram[mem_addr];
         end
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      int          addr;
      int          stage;  // 0: on the bus, 1: data returning
      logic [15:0] data;
   } rd_t;

   rd_t         pq[$];     // reads issued but not yet in the FIFO
   logic [15:0] fq[$];     // FIFO contents, head first
   logic [15:0] mram [0:32767];
   int          m_rd_addr;
   bit          m_fetch, m_last_wr, m_uf, m_done, m_en, m_we;
   int          m_addr;
   logic [15:0] m_wdata;

   task automatic model_reset();
      pq.delete();
      fq.delete();
      m_rd_addr = 0;
      m_fetch   = 0;
      m_last_wr = 1;
      m_uf      = 0;
      m_done    = 0;
      m_en      = 0;
      m_we      = 0;
      m_addr    = 0;
      m_wdata   = '0;
   endtask

   initial begin
      int          fill;
      int          g;          // 0 none, 1 display, 2 writer
      bit          push;
      logic [15:0] pdata;
      for (int i = 0; i < 32768; i++) mram[i] = init_word(i);
      model_reset();
      forever begin
         @(negedge clk_50);
         #2;
         if (!reset_n) begin
            model_reset();
            check("rst_wr_ready", wr_ready, 0);
            check("rst_mem_en", mem_en, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_pix_valid", pix_valid, 0);
            check("rst_pix_word", pix_word, 0);
            check("rst_underflow", underflow, 0);
            check("rst_frame_done", frame_done, 0);
            continue;
         end
         // Grant for this cycle from the arbitration rules.
         fill = fq.size() + pq.size();
         g = 0;
         if (frame_start || !(m_fetch && fill < DEPTH)) g = wr_valid ? 2 : 0;
         else if (fill < LW) g = 1;
         else if (m_last_wr || !wr_valid) g = 1;
         else g = 2;

         check("wr_ready", wr_ready, (g == 2));
         check("mem_en", mem_en, m_en);
         check("mem_we", mem_we, m_we);
         if (m_en) check("mem_addr", mem_addr, m_addr);
         if (m_en && m_we) check("mem_wdata", mem_wdata, m_wdata);
         check("pix_valid", pix_valid, (fq.size() > 0));
         check("pix_word", pix_word, (fq.size() > 0) ? fq[0] : 16'h0);
         check("underflow", underflow, m_uf);
         check("frame_done", frame_done, m_done);

         // Advance the model across the coming edge.
         if (m_en && m_we) mram[m_addr] = m_wdata;
         push = 0;
         pdata = '0;
         if (pq.size() > 0 && pq[0].stage == 1) begin
            push = 1;
            pdata = pq[0].data;
            void'(pq.pop_front());
         end
         foreach (pq[k]) begin
            if (pq[k].stage == 0) begin
               pq[k].data  = mram[pq[k].addr];
               pq[k].stage = 1;
            end
         end
         m_done = 0;
         m_en   = (g != 0);
         m_we   = (g == 2);
         if (g == 2) begin
            m_addr    = wr_addr;
            m_wdata   = wr_data;
            m_last_wr = 1;
         end
         if (frame_start) begin
            fq.delete();
            pq.delete();
            m_uf      = 0;
            m_rd_addr = 0;
            m_fetch   = 1;
         end else begin
            if (pix_pop) begin
               if (fq.size() > 0) void'(fq.pop_front());
               else m_uf = 1;
            end
            if (push) fq.push_back(pdata);
            if (g == 1) begin
               pq.push_back('{addr: m_rd_addr, stage: 0, data: 16'h0});
               m_addr    = m_rd_addr;
               m_last_wr = 0;
               if (m_rd_addr == WPF - 1) begin
                  m_done  = 1;
                  m_fetch = 0;
               end
               m_rd_addr++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bit seen;
      #1 reset_n = 1'b0;
      wr_valid = 1'b1;
      repeat (3) @(negedge clk_50);
      #3;
      check("reset_wr_ready_low", wr_ready, 0);
      check("reset_pix_valid", pix_valid, 0);
      @(negedge clk_50);
      reset_n  = 1'b1;
      wr_valid = 1'b0;
      repeat (2) @(negedge clk_50);

      // First fetch: latency and fill to depth with no writer.
      frame_start = 1'b1;
      @(negedge clk_50);
      frame_start = 1'b0;
      #3 check("lat_e0_valid", pix_valid, 0);
      @(negedge clk_50);
      #3 check("lat_e1_mem_en", mem_en, 1);
      check("lat_e1_addr", mem_addr, 0);
      check("lat_e1_valid", pix_valid, 0);
      @(negedge clk_50);
      #3 check("lat_e2_valid", pix_valid, 0);
      @(negedge clk_50);
      #3 check("lat_e3_valid", pix_valid, 1);
      check("lat_e3_word", pix_word, 16'hA5A5);
      repeat (15) @(negedge clk_50);
      #3 check("full_no_read", mem_en, 0);
      check("full_model_fill", fq.size(), 8);

      // Drain to low water with the writer asserting, then settle.
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_50);
         pix_pop  = 1'b1;
         wr_valid = 1'b1;
         wr_addr  = AW'($urandom_range(100, 200));
         wr_data  = DW'($urandom);
      end
      @(negedge clk_50);
      pix_pop = 1'b0;
      #3 check("lowwater_wr_blocked", wr_ready, 0);
      // Alternation region: occasional pops with the writer held.
      for (int i = 0; i < 160; i++) begin
         @(negedge clk_50);
         pix_pop = (i % 16 == 0);
         wr_addr = AW'($urandom_range(100, 200));
         wr_data = DW'($urandom);
      end

      // Underflow is sticky until the next frame_start.
      @(negedge clk_50);
      wr_valid = 1'b0;
      pix_pop = 1'b0;
      frame_start = 1'b1;
      @(negedge clk_50);
      frame_start = 1'b0;
      pix_pop = 1'b1;
      @(negedge clk_50);
      pix_pop = 1'b0;
      #3 check("uf_set", underflow, 1);
      repeat (6) @(negedge clk_50);
      #3 check("uf_sticky", underflow, 1);
      @(negedge clk_50);
      frame_start = 1'b1;
      @(negedge clk_50);
      frame_start = 1'b0;
      #3 check("uf_cleared", underflow, 0);

      // Random traffic with restarts and one reset mid-frame.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_50);
         if (i == 1500) begin
            reset_n = 1'b0;
            frame_start = 1'b0;
            #3 check("midreset_valid", pix_valid, 0);
            check("midreset_mem_en", mem_en, 0);
            continue;
         end
         reset_n     = 1'b1;
         frame_start = (i == 1501) || ($urandom_range(0, 149) == 0);
         pix_pop     = ($urandom_range(0, 9) < 6);
         wr_valid    = $urandom_range(0, 1);
         wr_addr     = AW'($urandom_range(0, 31));
         wr_data     = DW'($urandom);
      end

      // Complete frame.
      @(negedge clk_50);
      frame_start = 1'b1;
      pix_pop = 1'b0;
      wr_valid = 1'b0;
      @(negedge clk_50);
      frame_start = 1'b0;
      seen = 0;
      for (int c = 0; c < 60000 && !seen; c++) begin
         @(negedge clk_50);
         pix_pop  = pix_valid;
         wr_valid = ($urandom_range(0, 3) == 0);
         wr_addr  = AW'($urandom_range(20000, 32767));
         wr_data  = DW'($urandom);
         #3;
         if (frame_done) begin
            seen = 1;
            check("done_last_addr", mem_addr, WPF - 1);
         end
      end
      if (!seen) check("frame_done_timeout", 0, 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_50);
         pix_pop  = 1'b0;
         wr_valid = $urandom_range(0, 1);
         #3 check("idle_wr_ready", wr_ready, wr_valid);
      end

      repeat (3) @(negedge clk_50);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
